// File: rtl/qdr_lvds_pkg.sv
// Shared constants and helpers for the QDR LVDS DAC transmitter.
package qdr_lvds_pkg;

    localparam int SLOT_W   = 2;
    localparam int WORD_W   = 16;
    localparam int NIBBLE_W = 4;
    localparam int DATA_W   = 14;

    // Nibble of the frame word sent in a given slot, MSB nibble first.
    function automatic logic [NIBBLE_W-1:0] nibble_sel(
        input logic [WORD_W-1:0] word,
        input logic [SLOT_W-1:0] slot
    );
        logic [NIBBLE_W-1:0] n;
        case (slot)
            2'd0:    n = word[15:12];
            2'd1:    n = word[11:8];
            2'd2:    n = word[7:4];
            default: n = word[3:0];
        endcase
        return n;
    endfunction

endpackage

// File: rtl/qdr_lvds_dac_tx_lvds_pair.sv
// Complementary pin pair driver: p follows d, m is its exact complement.
module lvds_pair (
    input  logic d,
    output logic p,
    output logic m
);

    // Both legs are pure functions of d, so they stay complementary in every cycle.
    assign p = d;
    assign m = ~d;

endmodule

// File: rtl/qdr_lvds_dac_tx.sv
// Free-running 4-slot serializer: one 14-bit sample per frame, sent as four
// nibbles MSB first with a forwarded clock and a frame marker.
// Interface note: there is no valid/ready handshake; one sample is taken
// from data_in at the edge leaving slot 3, every 4 cycles, unconditionally.
module qdr_lvds_dac_tx
    import qdr_lvds_pkg::*;
#(
    parameter int DATA_W = 14,
    parameter int LANES  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    output logic [LANES-1:0]  DA,
    output logic              DACLKM,
    output logic              DAFRAMEM,
    output logic              DACLKP,
    output logic              DAFRAMEP
);

    // Zero padding below the left-justified sample.
    localparam int PAD_W = WORD_W - qdr_lvds_pkg::DATA_W;

    logic [SLOT_W-1:0] s;
    logic [WORD_W-1:0] w;

    // Slot counter and frame word; the word only reloads when leaving slot 3.
    always_ff @(posedge clk) begin
        if (reset) begin
            s <= '0;
            w <= '0;
        end else begin
            s <= s + SLOT_W'(1);
            if (s == SLOT_W'(3)) begin
                w <= {data_in, {PAD_W{1'b0}}};
            end
        end
    end

    // Lane data is decoded purely from the flops, never from data_in.
    assign DA = nibble_sel(w, s);

    // Forwarded clock toggles every slot: each edge delimits one nibble.
    lvds_pair u_daclk (
        .d (s[0]),
        .p (DACLKP),
        .m (DACLKM)
    );

    // Frame marker is high for slots 0-1; its rising edge tags the MSB nibble.
    lvds_pair u_daframe (
        .d (~s[1]),
        .p (DAFRAMEP),
        .m (DAFRAMEM)
    );

endmodule

// File: tb/tb_qdr_lvds_dac_tx.sv
// Self-checking bench for qdr_lvds_dac_tx.
module tb_qdr_lvds_dac_tx;

    logic        clk;
    logic        reset;
    logic [13:0] data_in;
    logic [3:0]  DA;
    logic        DACLKM;
    logic        DAFRAMEM;
    logic        DACLKP;
    logic        DAFRAMEP;

    int n_total = 0;
    int n_pass  = 0;

    qdr_lvds_dac_tx dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .DA       (DA),
        .DACLKM   (DACLKM),
        .DAFRAMEM (DAFRAMEM),
        .DACLKP   (DACLKP),
        .DAFRAMEP (DAFRAMEP)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Scoreboard model: exp_q[f] is the 16-bit word transmitted in frame f
    // since the last reset. Frame 0 is always zero; frame f (f>=1) carries the
    // sample present at the 4f-th edge after reset release.
    logic [15:0] exp_q[$];
    int          k;          // non-reset edges since the last reset edge
    bit          model_ok = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            exp_q.delete();
            exp_q.push_back(16'h0000);
            k = 0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            k = k + 1;
            if (k % 4 == 0) exp_q.push_back({data_in, 2'b00});
        end
    end

    // Compare process: every cycle once the model is seeded.
    always @(negedge clk) begin
        int          slot;
        logic [15:0] word;
        logic [3:0]  exp_da;
        if (model_ok) begin
            slot   = k % 4;
            word   = exp_q[k / 4];
            exp_da = 4'((word >> (4 * (3 - slot))) & 16'h000F);
            chk("model_DA", {12'h0, DA}, {12'h0, exp_da});
            chk("model_DACLKP", {15'h0, DACLKP}, {15'h0, slot[0]});
            chk("model_DAFRAMEP", {15'h0, DAFRAMEP}, {15'h0, (slot < 2)});
            chk("clk_complement", {15'h0, DACLKM}, {15'h0, ~DACLKP});
            chk("frame_complement", {15'h0, DAFRAMEM}, {15'h0, ~DAFRAMEP});
            if (!DAFRAMEP && DACLKP) chk("slot3_pad", {14'h0, DA[1:0]}, 16'h0000);
        end
    end

    // Driver tasks
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic lit(input string tag, input logic [3:0] da, input logic ck, input logic fr);
        chk({tag, "_DA"}, {12'h0, DA}, {12'h0, da});
        chk({tag, "_CLKP"}, {15'h0, DACLKP}, {15'h0, ck});
        chk({tag, "_FRP"}, {15'h0, DAFRAMEP}, {15'h0, fr});
    endtask

    // Called while sitting in slot 3: loads sample and checks the next frame.
    task automatic send_frame(input string tag, input logic [13:0] sample,
                              input logic [15:0] exp_word);
        logic [15:0] wv;
        wv = exp_word;
        data_in = sample;
        step(); lit({tag, "_s0"}, wv[15:12], 1'b0, 1'b1);
        step(); lit({tag, "_s1"}, wv[11:8],  1'b1, 1'b1);
        step(); lit({tag, "_s2"}, wv[7:4],   1'b0, 1'b0);
        step(); lit({tag, "_s3"}, wv[3:0],   1'b1, 1'b0);
    endtask

    initial begin
        reset   = 1'b1;
        data_in = 14'h0000;
        @(negedge clk);
        step();
        step();
        // In reset, slot 0 outputs.
        lit("reset", 4'h0, 1'b0, 1'b1);
        chk("reset_CLKM", {15'h0, DACLKM}, 16'h0001);
        chk("reset_FRM", {15'h0, DAFRAMEM}, 16'h0000);
        reset = 1'b0;
        step(); lit("rel_s1", 4'h0, 1'b1, 1'b1);
        step(); lit("rel_s2", 4'h0, 1'b0, 1'b0);
        step(); lit("rel_s3", 4'h0, 1'b1, 1'b0);

        send_frame("f1fff", 14'h1FFF, 16'h7FFC);
        send_frame("f2000", 14'h2000, 16'h8000);
        send_frame("f3fff", 14'h3FFF, 16'hFFFC);
        send_frame("f1bc3", 14'h1BC3, 16'h6F0C);

        // Sample changes mid-frame: current frame unaffected.
        data_in = 14'h3FFF;
        step(); lit("mid_s0", 4'hF, 1'b0, 1'b1);
        step(); lit("mid_s1", 4'hF, 1'b1, 1'b1);
        data_in = 14'h0000;
        step(); lit("mid_s2", 4'hF, 1'b0, 1'b0);
        step(); lit("mid_s3", 4'hC, 1'b1, 1'b0);
        step(); lit("zero_s0", 4'h0, 1'b0, 1'b1);
        step(); lit("zero_s1", 4'h0, 1'b1, 1'b1);
        step(); lit("zero_s2", 4'h0, 1'b0, 1'b0);
        step(); lit("zero_s3", 4'h0, 1'b1, 1'b0);

        // Reset asserted in slot 2 of a live frame.
        data_in = 14'h1BC3;
        step(); lit("pre_s0", 4'h6, 1'b0, 1'b1);
        step(); lit("pre_s1", 4'hF, 1'b1, 1'b1);
        step(); lit("pre_s2", 4'h0, 1'b0, 1'b0);
        reset = 1'b1;
        step(); lit("midrst", 4'h0, 1'b0, 1'b1);
        reset   = 1'b0;
        data_in = 14'h2000;
        step(); lit("rr_s1", 4'h0, 1'b1, 1'b1);
        step(); lit("rr_s2", 4'h0, 1'b0, 1'b0);
        step(); lit("rr_s3", 4'h0, 1'b1, 1'b0);
        step(); lit("rr_f_s0", 4'h8, 1'b0, 1'b1);
        step(); lit("rr_f_s1", 4'h0, 1'b1, 1'b1);
        step(); lit("rr_f_s2", 4'h0, 1'b0, 1'b0);
        step(); lit("rr_f_s3", 4'h0, 1'b1, 1'b0);

        // A few extra frames driven only against the model.
        for (int i = 0; i < 6; i++) begin
            data_in = 14'($urandom_range(0, 16383));
            repeat (4) step();
        end

        // Final report
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
